// File: rtl/uart_tx_engine_pkg.sv
// Shared UART types and CSR bit positions for the TX engine (and the future RX block).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int CSR_REQ_BIT     = 0;
  localparam int CSR_PAR_ODD_BIT = 1;
  localparam int DATA_BITS       = 8;

endpackage

// File: rtl/uart_tx_engine_if.sv
// Register-side view of the UART transmitter: memory-exported data/CSR in, line and status out.
interface uart_tx_engine_if;

  logic [31:0] uart_io_reg;
  logic [31:0] uart_csr_reg;
  logic        tx;
  logic        tx_busy;
  logic        tx_ack;

  modport master (
    output uart_io_reg,
    output uart_csr_reg,
    input  tx,
    input  tx_busy,
    input  tx_ack
  );

  modport slave (
    input  uart_io_reg,
    input  uart_csr_reg,
    output tx,
    output tx_busy,
    output tx_ack
  );

endinterface

// File: rtl/uart_tx_engine_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count as the bit-advance point.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 104,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == TERMINAL);

  always_ff @(posedge clk) begin
    if (rst || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: serialises the data register as 8N1 frames on a CSR bit-0 toggle.
// Define UART_TX_PARITY_EN to insert a parity bit (odd/even selected by CSR bit 1).
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_engine_if.slave   bus
);

  tx_state_t            state;
  logic                 req_seen;
  logic [DATA_BITS-1:0] shift_reg;
  logic [2:0]           bit_idx;
  logic                 tx_reg;
  logic                 busy_reg;
  logic                 ack_reg;
  logic                 req_pending;
  logic                 baud_clear;
  logic                 baud_tick;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`endif

  assign req_pending = (bus.uart_csr_reg[CSR_REQ_BIT] != req_seen);

  // The counter idles at zero, so every bit of a frame starts from a fresh count.
  assign baud_clear = (state == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .tick  (baud_tick)
  );

  assign bus.tx      = tx_reg;
  assign bus.tx_busy = busy_reg;
  assign bus.tx_ack  = ack_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_seen  <= 1'b0;
      shift_reg <= '0;
      bit_idx   <= '0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      ack_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_pending) begin
            shift_reg <= bus.uart_io_reg[DATA_BITS-1:0];
            req_seen  <= bus.uart_csr_reg[CSR_REQ_BIT];
`ifdef UART_TX_PARITY_EN
            par_bit   <= (^bus.uart_io_reg[DATA_BITS-1:0]) ^ bus.uart_csr_reg[CSR_PAR_ODD_BIT];
`endif
            busy_reg  <= 1'b1;
            tx_reg    <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            bit_idx <= '0;
            tx_reg  <= shift_reg[0];
            state   <= DATA;
          end
        end
        DATA: begin
          // tx is loaded with the next bit here so the line changes on the bit boundary.
          if (baud_tick) begin
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              tx_reg <= par_bit;
              state  <= PARITY;
`else
              tx_reg <= 1'b1;
              state  <= STOP;
`endif
            end else begin
              tx_reg <= shift_reg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            tx_reg <= 1'b1;
            state  <= STOP;
          end
        end
`endif
        STOP: begin
          if (baud_tick) begin
            ack_reg  <= ~ack_reg;
            busy_reg <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Consumer side of the memory-mapped UART registers: watches the UART data register and the UART CSR register exported by the data memory, and serialises bytes onto a TX line as 8N1 frames (8O1/8E1 with the optional feature).
- Software requests a transmit by writing the byte to the data register, then flipping CSR bit 0 (request toggle).
- Sits beside the data memory at top level; tx drives the board UART pin.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200); legal range 2..65535.
- CNT_W, 16, width of baud counter; must satisfy 2**CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- uart_io_reg  input  32  UART data register from memory; bits [7:0] = byte to send, [31:8] ignored
- uart_csr_reg  input  32  UART CSR from memory; bit0 = request toggle, bit1 = parity odd(1)/even(0) (used only with the optional feature), others ignored
- tx  output  1  serial line, idle high
- tx_busy  output  1  high from frame acceptance through the last stop-bit cycle
- tx_ack  output  1  toggles once per completed frame; status path for a future CSR read-back

Behaviour:
- Reset values: tx=1, tx_busy=0, tx_ack=0, state=IDLE, req_seen=0, baud counter=0, bit index=0, shift register=0. Reset is honoured in any state, including mid-frame; tx returns high on the next edge and the partial frame is dropped.
- req_seen holds the CSR bit0 value most recently accepted. A pending request is uart_csr_reg[0] != req_seen.
- States and transitions:
  - IDLE: tx=1. On the edge where a request is pending: latch data[7:0] into the shift register; latch the parity mode if the feature is enabled; set req_seen = csr[0] and tx_busy=1; go to START. Data written after acceptance does not affect the frame.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
  - DATA: tx = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. At the end of each bit, shift right and increment the index; after index 7 completes, go to PARITY (feature on) or STOP.
  - PARITY: present only with the optional feature.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the last cycle: toggle tx_ack and go to IDLE; tx_busy falls on that same edge.
- Latency: tx falls exactly 1 clock after the cycle in which the pending condition is first true in IDLE. A frame occupies exactly 10*CLKS_PER_BIT cycles (11 with parity).
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - Clears on every state entry.
  - Wraps to 0 at the terminal count, which is the bit-advance point.
- Back-to-back frames: if a request is pending when STOP ends, IDLE accepts it on the next edge. That gives exactly one idle-high cycle between frames.
- Requests during busy:
  - One toggle during busy stays pending and is served afterwards.
  - Two toggles during busy cancel: csr[0] equals req_seen again, so no frame is sent. This is documented software behaviour, not an error.
- Arithmetic: unsigned only; the bit index is 3 bits and never exceeds 7; no other wrap conditions.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - tx = XOR of the 8 latched data bits, XOR the latched csr[1] (odd when csr[1]=1).
  - Lasts one bit time; frame length becomes 11 bits.
- Undefined: csr[1] is ignored, there is no PARITY state, and frames are 8N1.

Decomposition:
- Package uart_pkg:
  - enum tx_state_t {IDLE, START, DATA, PARITY, STOP}; PARITY is kept in the enum even when the feature is compiled out.
  - Constants CSR_REQ_BIT=0, CSR_PAR_ODD_BIT=1, DATA_BITS=8.
- One sub-module: uart_baud_tick.
  - Counter with a clear input; outputs tick at count CLKS_PER_BIT-1.
  - Reused later by an RX block.

Test Plan (CLKS_PER_BIT=4 in simulation):
- Reset, hold csr=0 for 50 cycles -> tx=1, tx_busy=0, tx_ack=0 throughout.
- data=0x55, then csr bit0 0->1 -> tx low 1 cycle later; line sequence 0,1,0,1,0,1,0,1,0,1 with each bit exactly 4 cycles; tx_ack=1 after 40 cycles; tx_busy low on that edge.
- data=0xA3, toggle; change data to 0xFF 5 cycles later -> received byte is 0xA3.
- Toggle once at cycle 10 of a busy frame -> second frame starts with exactly 1 idle cycle after the first stop bit; tx_ack toggles twice. Toggle twice during busy -> no second frame.
- Assert rst in DATA bit 3 -> tx=1 next edge, tx_busy=0, tx_ack=0, no further edges on tx. With csr[0]=1 still set after rst deasserts -> a new frame starts, since req_seen resets to 0.
- With UART_TX_PARITY_EN: data=0x07, csr[1]=0 -> parity bit 1 and frame length 44 cycles; csr[1]=1 -> parity bit 0.
